// File: rtl/seq_divider.sv
// -----------------------------------------------------------------------------
// seq_divider : sequential unsigned restoring divider.
//
// Produces one quotient bit per clock. Each trial subtraction runs through an
// addsub instance of width dw+1 that is hard-wired to subtract.
//
// Handshake: start is accepted on a rising clk edge whenever busy=0 (IDLE or
// DONE). busy is high while the division runs. done pulses for one cycle, and
// the results are valid from that cycle until the next accepted start.
//
// Ports:
//   clk          in   1   clock, rising edge
//   reset        in   1   asynchronous, active-high reset
//   start        in   1   request a division (ignored while busy)
//   dataa        in   dw  dividend, captured on the accepting edge
//   datab        in   dw  divisor, captured on the accepting edge
//   busy         out  1   division in progress (RUN or ZERO)
//   done         out  1   one-cycle completion pulse (DONE)
//   div_by_zero  out  1   captured divisor was zero; held with the results
//   quotient     out  dw  result quotient (all ones on divide by zero)
//   remainder    out  dw  result remainder (dividend on divide by zero)
// -----------------------------------------------------------------------------

// Adder/subtractor. add_sub=1 adds and add_sub=0 subtracts (dataa - datab).
module addsub #(
    parameter int width = 9
) (
    input  logic [width-1:0] dataa,
    input  logic [width-1:0] datab,
    input  logic             add_sub,
    output logic [width-1:0] result
);
    assign result = add_sub ? (dataa + datab) : (dataa - datab);
endmodule

module seq_divider #(
    parameter int dw = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [dw-1:0] dataa,
    input  logic [dw-1:0] datab,
    output logic          busy,
    output logic          done,
    output logic          div_by_zero,
    output logic [dw-1:0] quotient,
    output logic [dw-1:0] remainder
);
    localparam int CW = $clog2(dw + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] ZERO = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [dw-1:0] q_q, q_d;        // dividend shifting out, quotient shifting in
    logic [dw-1:0] d_q, d_d;        // captured divisor
    logic [dw:0]   r_q, r_d;        // partial remainder, one guard bit
    logic [CW-1:0] cnt_q, cnt_d;    // iterations still to run
    logic [dw-1:0] quot_q, quot_d;
    logic [dw-1:0] rem_q, rem_d;
    logic          dbz_q, dbz_d;

    // Partial remainder shifted left with the next dividend bit brought in.
    logic [dw:0] rem_shift;
    logic [dw:0] trial;

    assign rem_shift = {r_q[dw-1:0], q_q[dw-1]};

    addsub #(.width(dw + 1)) u_sub (
        .dataa   (rem_shift),
        .datab   ({1'b0, d_q}),
        .add_sub (1'b0),
        .result  (trial)
    );

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        d_d     = d_q;
        r_d     = r_q;
        cnt_d   = cnt_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        case (state_q)
            // DONE accepts a new start exactly like IDLE, giving back-to-back
            // operation without an idle bubble.
            IDLE, DONE: begin
                if (start) begin
                    q_d     = dataa;
                    d_d     = datab;
                    r_d     = '0;
                    cnt_d   = CW'(dw);
                    dbz_d   = 1'b0;
                    state_d = (datab == '0) ? ZERO : RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                // Guard bit clear means the trial subtraction did not borrow.
                if (!trial[dw]) begin
                    r_d = trial;
                    q_d = {q_q[dw-2:0], 1'b1};
                end else begin
                    r_d = rem_shift;
                    q_d = {q_q[dw-2:0], 1'b0};
                end
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = DONE;
                    quot_d  = q_d;
                    rem_d   = r_d[dw-1:0];
                end
            end
            ZERO: begin
                // No iterations: q_q still holds the captured dividend.
                state_d = DONE;
                quot_d  = '1;
                rem_d   = q_q;
                dbz_d   = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            q_q     <= '0;
            d_q     <= '0;
            r_q     <= '0;
            cnt_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            d_q     <= d_d;
            r_q     <= r_d;
            cnt_q   <= cnt_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    assign busy        = (state_q == RUN) || (state_q == ZERO);
    assign done        = (state_q == DONE);
    assign div_by_zero = dbz_q;
    assign quotient    = quot_q;
    assign remainder   = rem_q;
endmodule
